ifu_fetch: RTL and testbench

Instruction fetch unit for the xfan100 core. It generates the program counter, issues reads to the synchronous instruction memory (the `tb_mem_init`-style instruction store), and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake. It sits directly downstream of the instruction memory and upstream of decode, and supports a single-cycle redirect (branch/jump flush).

---
 rtl/ifu_fetch.sv | 171 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit for the xfan100 core.
//
// Generates the program counter and issues one read per cycle to a
// synchronous instruction memory. Each returned word is buffered together
// with its PC in a small FIFO, and the FIFO head is presented to decode over
// a valid/ready handshake. A one-cycle redirect flushes everything and
// restarts fetch at a new PC.
//
// Ports
//   sys_clk       in   clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   imem_req      out  instruction memory read strobe
//   imem_addr     out  read byte address (word aligned, equals the PC)
//   imem_rdata    in   read data, valid the cycle after imem_req
//   redirect_vld  in   flush the pipeline and restart fetch
//   redirect_pc   in   restart address (bits [1:0] ignored)
//   instr_vld     out  head instruction available to decode
//   instr         out  head instruction
//   instr_pc      out  PC of the head instruction
//   instr_rdy     in   decode accepts the head this cycle
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                INSTR_SIZE = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    input  logic                  redirect_vld,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  instr_vld,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [ADDR_W-1:0]     instr_pc,
    input  logic                  instr_rdy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]     pc_reg,       pc_next;
    logic [ADDR_W-1:0]     resp_pc_reg,  resp_pc_next;
    logic                  inflight_reg, inflight_next;
    logic [CNT_W-1:0]      cnt_reg,      cnt_next;
    logic [PTR_W-1:0]      wr_ptr_reg,   wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg,   rd_ptr_next;

    logic [INSTR_SIZE-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     pc_mem    [FIFO_DEPTH];

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        credit_used;

    // ------------------------------------------------------------------
    // Issue / handshake decode
    // ------------------------------------------------------------------
    // Every outstanding request holds a FIFO slot in reserve, so the
    // buffer can never be asked to accept more than it holds.
    assign credit_used = {1'b0, cnt_reg} + (CNT_W+1)'(inflight_reg);

    // Reset gating keeps the strobe low even in the window between the
    // asynchronous assertion and the next clock edge.
    assign issue = sys_rst_n && !redirect_vld &&
                   (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    // A response landing in a redirect cycle belongs to the flushed path.
    assign push  = inflight_reg && !redirect_vld;

    assign instr_vld = (cnt_reg != '0) && !redirect_vld;
    assign pop       = instr_vld && instr_rdy;

    assign imem_req  = issue;
    assign imem_addr = pc_reg;
    assign instr     = instr_mem[rd_ptr_reg];
    assign instr_pc  = pc_mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_next       = pc_reg;
        resp_pc_next  = resp_pc_reg;
        inflight_next = inflight_reg;
        cnt_next      = cnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;

        if (redirect_vld) begin
            // Masking rather than slicing keeps the restart PC word aligned.
            pc_next       = redirect_pc & ~ADDR_W'(3);
            inflight_next = 1'b0;
            cnt_next      = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end else begin
            if (issue) begin
                pc_next       = pc_reg + ADDR_W'(4);
                resp_pc_next  = pc_reg;
                inflight_next = 1'b1;
            end else begin
                inflight_next = 1'b0;
            end

            // Depth is a power of two, so pointers wrap on overflow.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   cnt_next = cnt_reg + CNT_W'(1);
                2'b01:   cnt_next = cnt_reg - CNT_W'(1);
                default: cnt_next = cnt_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pc_reg       <= RESET_PC;
            resp_pc_reg  <= '0;
            inflight_reg <= 1'b0;
            cnt_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            pc_reg       <= pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            cnt_reg      <= cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer storage
    // ------------------------------------------------------------------
    // Cleared on reset so that instr / instr_pc read zero while in reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= resp_pc_reg;
        end
    end

    // The credit rule makes a push into a full buffer impossible.
    assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                     !(push && (cnt_reg == CNT_W'(FIFO_DEPTH))))
        else $error("ifu_fetch: push into full instruction buffer");

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam int DEPTH = 4;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        instr_vld;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_rdy;

    int checks = 0;
    int errors = 0;

    ifu_fetch #(
        .INSTR_SIZE(32),
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect_vld(redirect_vld),
        .redirect_pc (redirect_pc),
        .instr_vld   (instr_vld),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_rdy   (instr_rdy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Instruction store contents: word k holds 0x1000 + k.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // Synchronous memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge sys_clk) begin
        imem_rdata <= imem_req ? memf(imem_addr) : 32'hDEAD_BEEF;
    end

    // ------------------------------------------------------------------
    // Behavioural model: queue of buffered {instr, pc}, next PC, and the
    // PC of the one outstanding request (if any).
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_resp_pc;
    int          m_inflight;

    task automatic model_reset();
        m_q.delete();
        m_pc       = 32'h0000_0000;
        m_resp_pc  = 32'h0;
        m_inflight = 0;
    endtask

    task automatic model_update();
        logic   req;
        logic   do_pop;
        entry_t e;
        if (redirect_vld) begin
            m_q.delete();
            m_inflight = 0;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            return;
        end
        req    = (m_q.size() + m_inflight) < DEPTH;
        do_pop = (m_q.size() != 0) && instr_rdy;
        if (do_pop) void'(m_q.pop_front());
        if (m_inflight != 0) begin
            e.instr = memf(m_resp_pc);
            e.pc    = m_resp_pc;
            m_q.push_back(e);
        end
        if (req) begin
            m_resp_pc  = m_pc;
            m_pc       = m_pc + 32'd4;
            m_inflight = 1;
        end else begin
            m_inflight = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compare_all();
        logic exp_req;
        logic exp_vld;
        exp_req = sys_rst_n && !redirect_vld && ((m_q.size() + m_inflight) < DEPTH);
        exp_vld = sys_rst_n && !redirect_vld && (m_q.size() != 0);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_vld", {31'd0, instr_vld}, {31'd0, exp_vld});
        if (exp_vld) begin
            chk("instr", instr, m_q[0].instr);
            chk("instr_pc", instr_pc, m_q[0].pc);
        end
        if (!sys_rst_n) begin
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge sys_clk);
        sys_rst_n    = rst;
        instr_rdy    = rdy;
        redirect_vld = redir;
        redirect_pc  = rpc;
        if (!rst) model_reset();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge sys_clk);
        if (sys_rst_n) model_update();
    endtask

    task automatic tick(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
        drive(rst, rdy, redir, rpc);
        advance();
    endtask

    initial begin
        int          nreq;
        int          seen;
        logic [31:0] got_pc[$];

        sys_rst_n = 1'b0; instr_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
        model_reset();

        // ---------------- Reset and first fetches ----------------
        repeat (2) tick(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("rst_req_lit", {31'd0, imem_req}, 32'd0);
        chk("rst_addr_lit", imem_addr, 32'h0);
        advance();

        drive(1, 1, 0, 0);
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        advance();
        drive(1, 1, 0, 0);
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_vld", {31'd0, instr_vld}, 32'd0);
        advance();
        drive(1, 1, 0, 0);
        chk("c2_vld", {31'd0, instr_vld}, 32'd1);
        chk("c2_instr", instr, 32'h1000);
        chk("c2_pc", instr_pc, 32'h0);
        advance();
        drive(1, 1, 0, 0);
        chk("c3_instr", instr, 32'h1001);
        chk("c3_pc", instr_pc, 32'h4);
        advance();
        repeat (6) tick(1, 1, 0, 0);

        // ---------------- Redirect with in-flight data ----------------
        drive(1, 1, 1, 32'h203);
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        chk("redir_vld", {31'd0, instr_vld}, 32'd0);
        advance();
        drive(1, 1, 0, 0);
        chk("redir_r1_addr", imem_addr, 32'h200);
        chk("redir_r1_req", {31'd0, imem_req}, 32'd1);
        advance();
        drive(1, 1, 0, 0);
        chk("redir_r2_vld", {31'd0, instr_vld}, 32'd0);
        advance();
        drive(1, 1, 0, 0);
        chk("redir_r3_vld", {31'd0, instr_vld}, 32'd1);
        chk("redir_r3_pc", instr_pc, 32'h200);
        chk("redir_r3_instr", instr, 32'h1080);
        advance();
        repeat (4) tick(1, 1, 0, 0);

        // ---------------- Backpressure from reset ----------------
        repeat (2) tick(0, 0, 0, 0);
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0);
            if (imem_req) nreq++;
            advance();
        end
        chk("bp_req_count", nreq, 32'd4);
        chk("bp_model_cnt", m_q.size(), 32'd4);
        drive(1, 1, 0, 0);
        chk("bp_full_req", {31'd0, imem_req}, 32'd0);
        if (instr_vld) got_pc.push_back(instr_pc);
        advance();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 0);
            if (instr_vld) got_pc.push_back(instr_pc);
            if (imem_req && seen == 0) begin
                chk("bp_resume_addr", imem_addr, 32'h10);
                seen = 1;
            end
            advance();
        end
        chk("bp_resume_seen", seen, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < got_pc.size()) chk("bp_drain_pc", got_pc[i], 32'(i * 4));
            else chk("bp_drain_missing", got_pc.size(), 32'd5);
        end

        // ---------------- Redirect while full ----------------
        repeat (8) tick(1, 0, 0, 0);
        chk("full_model_cnt", m_q.size(), 32'd4);
        drive(1, 0, 1, 32'h40);
        chk("full_redir_vld", {31'd0, instr_vld}, 32'd0);
        chk("full_redir_req", {31'd0, imem_req}, 32'd0);
        advance();
        drive(1, 0, 0, 0);
        chk("full_flush_vld", {31'd0, instr_vld}, 32'd0);
        chk("full_new_addr", imem_addr, 32'h40);
        advance();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0);
            if (instr_vld && seen == 0) begin
                chk("full_first_pc", instr_pc, 32'h40);
                seen = 1;
            end
            advance();
        end
        chk("full_first_seen", seen, 32'd1);

        // ---------------- Address wrap and random traffic ----------------
        tick(1, 1, 1, 32'hFFFF_FFF8);
        drive(1, 1, 0, 0);
        chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        advance();
        drive(1, 1, 0, 0);
        chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        advance();
        drive(1, 1, 0, 0);
        chk("wrap_a2", imem_addr, 32'h0000_0000);
        advance();
        for (int i = 0; i < 400; i++) begin
            tick(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), $urandom);
        end

        // ---------------- Mid-run asynchronous reset ----------------
        repeat (2) tick(0, 0, 0, 0);
        repeat (3) tick(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("mr_model_cnt", m_q.size(), 32'd2);
        chk("mr_model_inflight", m_inflight, 32'd1);
        chk("mr_vld_before", {31'd0, instr_vld}, 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk("mr_req_drop", {31'd0, imem_req}, 32'd0);
        chk("mr_vld_drop", {31'd0, instr_vld}, 32'd0);
        compare_all();
        advance();
        tick(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("mr_c0_addr", imem_addr, 32'h0);
        chk("mr_c0_req", {31'd0, imem_req}, 32'd1);
        advance();
        drive(1, 1, 0, 0);
        chk("mr_c1_vld", {31'd0, instr_vld}, 32'd0);
        advance();
        drive(1, 1, 0, 0);
        chk("mr_c2_pc", instr_pc, 32'h0);
        chk("mr_c2_instr", instr, 32'h1000);
        advance();
        repeat (6) tick(1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
